controlador_de_alarma: RTL and testbench

Sequencing controller for the alarm-signal decoder path: temperatura, manual, sobrecarga and humo drive bocina, extractor and interrupcion.
- Synchronizes and debounces raw sensor and pushbutton inputs.
- Latches alarm causes and runs a state machine with horn cadence, operator acknowledge (silence) and timed extractor post-purge.
- Holds a sticky interruption latch.
- Sits between board inputs and the actuator drivers.

---
 rtl/alarma_pkg.sv | 20 ++
 rtl/filtro_antirrebote.sv | 47 ++++
 rtl/controlador_de_alarma.sv | 193 +++++++++++++++++++
 tb/tb_controlador_de_alarma.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alarma_pkg.sv
// Shared definitions for the alarm sequencing controller: state encoding
// and the bit positions of each cause inside the latched cause vector.
package alarma_pkg;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        ALARMA   = 2'd1,
        SILENCIO = 2'd2,
        PURGA    = 2'd3
    } estado_t;

    localparam int CAUSA_TEMP  = 3;
    localparam int CAUSA_MAN   = 2;
    localparam int CAUSA_SOBRE = 1;
    localparam int CAUSA_HUMO  = 0;

    // Causes that sound the horn; overload alone only cuts power.
    localparam logic [3:0] MASCARA_BOCINA = 4'b1101;

endpackage

// File: rtl/filtro_antirrebote.sv
// One-bit input conditioner: two-flop synchronizer followed by a debounce
// counter that accepts a new level only after DEB_CICLOS consecutive cycles
// of disagreement with the current filtered value.
module filtro_antirrebote #(
    parameter int DEB_CICLOS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic entrada,
    output logic salida
);

    localparam int CW = $clog2(DEB_CICLOS + 1);
    localparam logic [CW-1:0] LIMITE = CW'(DEB_CICLOS - 1);

    logic          sinc_a;
    logic          sinc_b;
    logic [CW-1:0] cuenta;

    // Bring the asynchronous raw input into the clock domain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sinc_a <= 1'b0;
            sinc_b <= 1'b0;
        end else begin
            sinc_a <= entrada;
            sinc_b <= sinc_a;
        end
    end

    // Count disagreement cycles; any agreement restarts the count, and the
    // count never runs past the acceptance point so it cannot wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cuenta <= '0;
            salida <= 1'b0;
        end else if (sinc_b == salida) begin
            cuenta <= '0;
        end else if (cuenta >= LIMITE) begin
            salida <= sinc_b;
            cuenta <= '0;
        end else begin
            cuenta <= cuenta + 1'b1;
        end
    end

endmodule

// File: rtl/controlador_de_alarma.sv
// Alarm sequencing controller: filters the sensors and acknowledge button,
// latches alarm causes, sequences horn cadence, silence and extractor
// post-purge, and keeps a sticky power-cut latch.
module controlador_de_alarma
    import alarma_pkg::*;
#(
    parameter int DEB_CICLOS   = 4,
    parameter int PURGA_CICLOS = 16,
    parameter int BOCINA_SEMI  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       temperatura,
    input  logic       manual,
    input  logic       sobrecarga,
    input  logic       humo,
    input  logic       reconocer,
    output logic       bocina,
    output logic       extractor,
    output logic       interrupcion,
    output logic [1:0] estado,
    output logic [3:0] causa
);

    localparam int HW = $clog2(BOCINA_SEMI + 1);
    localparam int PW = $clog2(PURGA_CICLOS + 1);
    localparam logic [HW-1:0] H_LIM = HW'(BOCINA_SEMI - 1);
    localparam logic [PW-1:0] P_LIM = PW'(PURGA_CICLOS - 1);

    logic t_f, m_f, s_f, h_f, rec_f;
    logic rec_prev;
    logic ack;
    logic req_ext, req_boc, req_int;
    logic [3:0] actual;
    logic [3:0] causa_acc;
    logic       nueva_causa;
    logic       ir_purga;

    estado_t       estado_act, estado_sig;
    logic [HW-1:0] hcnt, hcnt_sig;
    logic [PW-1:0] pcnt, pcnt_sig;
    logic          bocina_sig, extractor_sig;
    logic [3:0]    causa_sig;

    filtro_antirrebote #(.DEB_CICLOS(DEB_CICLOS)) u_f_temp (
        .clk(clk), .rst_n(rst_n), .entrada(temperatura), .salida(t_f));
    filtro_antirrebote #(.DEB_CICLOS(DEB_CICLOS)) u_f_man (
        .clk(clk), .rst_n(rst_n), .entrada(manual), .salida(m_f));
    filtro_antirrebote #(.DEB_CICLOS(DEB_CICLOS)) u_f_sobre (
        .clk(clk), .rst_n(rst_n), .entrada(sobrecarga), .salida(s_f));
    filtro_antirrebote #(.DEB_CICLOS(DEB_CICLOS)) u_f_humo (
        .clk(clk), .rst_n(rst_n), .entrada(humo), .salida(h_f));
    filtro_antirrebote #(.DEB_CICLOS(DEB_CICLOS)) u_f_rec (
        .clk(clk), .rst_n(rst_n), .entrada(reconocer), .salida(rec_f));

    assign actual[CAUSA_TEMP]  = t_f;
    assign actual[CAUSA_MAN]   = m_f;
    assign actual[CAUSA_SOBRE] = s_f;
    assign actual[CAUSA_HUMO]  = h_f;

    assign req_ext = h_f | m_f;
    assign req_boc = t_f | m_f | h_f;
    assign req_int = s_f | m_f;
    assign ack     = rec_f & ~rec_prev;

    assign causa_acc   = causa | actual;
    assign ir_purga    = causa_acc[CAUSA_MAN] | causa_acc[CAUSA_HUMO];
    assign nueva_causa = |(actual & ~causa & MASCARA_BOCINA);
    assign estado      = estado_act;

    // Remember the previous filtered acknowledge level for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) rec_prev <= 1'b0;
        else        rec_prev <= rec_f;
    end

    // Sticky power-cut: set wins over an acknowledge clear.
    always_ff @(posedge clk) begin
        if (!rst_n)       interrupcion <= 1'b0;
        else if (req_int) interrupcion <= 1'b1;
        else if (ack)     interrupcion <= 1'b0;
    end

    // State register together with the registered actuator outputs and timers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_act <= REPOSO;
            bocina     <= 1'b0;
            extractor  <= 1'b0;
            causa      <= 4'b0000;
            hcnt       <= '0;
            pcnt       <= '0;
        end else begin
            estado_act <= estado_sig;
            bocina     <= bocina_sig;
            extractor  <= extractor_sig;
            causa      <= causa_sig;
            hcnt       <= hcnt_sig;
            pcnt       <= pcnt_sig;
        end
    end

    // Next state, next outputs and timer updates for the alarm sequence.
    always_comb begin
        estado_sig    = estado_act;
        bocina_sig    = 1'b0;
        extractor_sig = 1'b0;
        causa_sig     = causa;
        hcnt_sig      = hcnt;
        pcnt_sig      = pcnt;
        case (estado_act)
            REPOSO: begin
                causa_sig = 4'b0000;
                hcnt_sig  = '0;
                pcnt_sig  = '0;
                if (req_boc) begin
                    estado_sig    = ALARMA;
                    causa_sig     = actual;
                    bocina_sig    = 1'b1;
                    extractor_sig = req_ext;
                end
            end
            ALARMA: begin
                causa_sig = causa_acc;
                if (!req_boc) begin
                    if (ir_purga) begin
                        estado_sig    = PURGA;
                        extractor_sig = 1'b1;
                        pcnt_sig      = '0;
                    end else begin
                        estado_sig = REPOSO;
                        causa_sig  = 4'b0000;
                    end
                end else if (ack) begin
                    estado_sig    = SILENCIO;
                    extractor_sig = req_ext;
                end else begin
                    extractor_sig = req_ext;
                    if (hcnt >= H_LIM) begin
                        bocina_sig = ~bocina;
                        hcnt_sig   = '0;
                    end else begin
                        bocina_sig = bocina;
                        hcnt_sig   = hcnt + 1'b1;
                    end
                end
            end
            SILENCIO: begin
                causa_sig = causa_acc;
                if (nueva_causa) begin
                    estado_sig    = ALARMA;
                    bocina_sig    = 1'b1;
                    hcnt_sig      = '0;
                    extractor_sig = req_ext;
                end else if (!req_boc) begin
                    if (ir_purga) begin
                        estado_sig    = PURGA;
                        extractor_sig = 1'b1;
                        pcnt_sig      = '0;
                    end else begin
                        estado_sig = REPOSO;
                        causa_sig  = 4'b0000;
                    end
                end else begin
                    extractor_sig = req_ext;
                end
            end
            PURGA: begin
                extractor_sig = 1'b1;
                if (req_boc) begin
                    estado_sig    = ALARMA;
                    causa_sig     = causa_acc;
                    bocina_sig    = 1'b1;
                    hcnt_sig      = '0;
                    pcnt_sig      = '0;
                    extractor_sig = req_ext;
                end else if (pcnt >= P_LIM) begin
                    estado_sig    = REPOSO;
                    extractor_sig = 1'b0;
                    causa_sig     = 4'b0000;
                    pcnt_sig      = '0;
                end else begin
                    pcnt_sig = pcnt + 1'b1;
                end
            end
            default: begin
                estado_sig = REPOSO;
                causa_sig  = 4'b0000;
            end
        endcase
    end

endmodule

// File: tb/tb_controlador_de_alarma.sv
// Self-checking bench for the alarm controller: each stimulus step pushes
// the outputs it must produce, tagged with the cycle they are due, into a
// scoreboard that a negedge monitor drains against the DUT.
module tb_controlador_de_alarma;

    localparam int DEB  = 4;
    localparam int PUR  = 16;
    localparam int SEMI = 8;
    localparam int LAT  = DEB + 3;

    localparam int S_BOC = 0;
    localparam int S_EXT = 1;
    localparam int S_INT = 2;
    localparam int S_EST = 3;
    localparam int S_CAU = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       temperatura, manual, sobrecarga, humo, reconocer;
    logic       bocina, extractor, interrupcion;
    logic [1:0] estado;
    logic [3:0] causa;

    controlador_de_alarma #(
        .DEB_CICLOS(DEB), .PURGA_CICLOS(PUR), .BOCINA_SEMI(SEMI)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .temperatura(temperatura), .manual(manual), .sobrecarga(sobrecarga),
        .humo(humo), .reconocer(reconocer),
        .bocina(bocina), .extractor(extractor), .interrupcion(interrupcion),
        .estado(estado), .causa(causa)
    );

    always #5 clk = ~clk;

    int cyc = 0;

    // Count rising edges so expectations can be scheduled by cycle number.
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        string      tag;
        int         sel;
        logic [3:0] val;
    } expect_t;

    expect_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %b expected %b (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    function automatic logic [3:0] sample(input int sel);
        case (sel)
            S_BOC:   return {3'b000, bocina};
            S_EXT:   return {3'b000, extractor};
            S_INT:   return {3'b000, interrupcion};
            S_EST:   return {2'b00, estado};
            default: return causa;
        endcase
    endfunction

    task automatic expectAt(input int offset, input string tag, input int sel, input logic [3:0] val);
        expect_t e;
        e.due = cyc + offset;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic expectAll(input int offset, input string tag, input logic boc, input logic ext,
                             input logic intr, input logic [1:0] est, input logic [3:0] cau);
        expectAt(offset, {tag, "_bocina"}, S_BOC, {3'b000, boc});
        expectAt(offset, {tag, "_extractor"}, S_EXT, {3'b000, ext});
        expectAt(offset, {tag, "_interrupcion"}, S_INT, {3'b000, intr});
        expectAt(offset, {tag, "_estado"}, S_EST, {2'b00, est});
        expectAt(offset, {tag, "_causa"}, S_CAU, cau);
    endtask

    task automatic applyStimulus(input logic t, input logic m, input logic s, input logic h, input logic r);
        temperatura = t;
        manual      = m;
        sobrecarga  = s;
        humo        = h;
        reconocer   = r;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drain every expectation that falls due on this cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                checkOutput(sb[i].tag, sample(sb[i].sel), sb[i].val);
                sb.delete(i);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(1, 1, 1, 1, 1);
        tick(2);
        $display("[TB] reset with all inputs high");
        expectAll(0, "reset", 0, 0, 0, 2'd0, 4'b0000);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        expectAll(10, "idle", 0, 0, 0, 2'd0, 4'b0000);
        tick(12);

        $display("[TB] short temperature glitch, then smoke");
        applyStimulus(1, 0, 0, 0, 0);
        expectAt(10, "glitch_estado", S_EST, 4'd0);
        expectAt(10, "glitch_bocina", S_BOC, 4'd0);
        tick(3);
        applyStimulus(0, 0, 0, 0, 0);
        tick(9);
        applyStimulus(0, 0, 0, 1, 0);
        expectAt(LAT - 1, "humo_pre_estado", S_EST, 4'd0);
        expectAll(LAT, "humo_alarma", 1, 1, 0, 2'd1, 4'b0001);
        expectAt(LAT + SEMI - 1, "horn_hold1", S_BOC, 4'd1);
        expectAt(LAT + SEMI, "horn_tog1", S_BOC, 4'd0);
        expectAt(LAT + 2 * SEMI - 1, "horn_hold2", S_BOC, 4'd0);
        expectAt(LAT + 2 * SEMI, "horn_tog2", S_BOC, 4'd1);
        tick(25);

        $display("[TB] acknowledge, then new temperature cause");
        applyStimulus(0, 0, 0, 1, 1);
        expectAt(LAT - 1, "ack_pre_estado", S_EST, 4'd1);
        expectAt(LAT, "ack_estado", S_EST, 4'd2);
        expectAt(LAT, "ack_bocina", S_BOC, 4'd0);
        expectAt(LAT, "ack_extractor", S_EXT, 4'd1);
        tick(6);
        applyStimulus(0, 0, 0, 1, 0);
        tick(6);
        applyStimulus(1, 0, 0, 1, 0);
        expectAt(LAT - 1, "newcause_pre_estado", S_EST, 4'd2);
        expectAt(LAT, "newcause_estado", S_EST, 4'd1);
        expectAt(LAT, "newcause_bocina", S_BOC, 4'd1);
        expectAt(LAT, "newcause_causa", S_CAU, 4'b1001);
        tick(10);

        $display("[TB] silence, causes clear, extractor purge");
        applyStimulus(1, 0, 0, 1, 1);
        expectAt(LAT, "ack2_estado", S_EST, 4'd2);
        tick(6);
        applyStimulus(1, 0, 0, 1, 0);
        tick(6);
        applyStimulus(0, 0, 0, 0, 0);
        expectAt(LAT - 1, "purge_pre_estado", S_EST, 4'd2);
        expectAt(LAT, "purge_estado", S_EST, 4'd3);
        expectAt(LAT, "purge_extractor", S_EXT, 4'd1);
        expectAt(LAT + PUR - 1, "purge_last_estado", S_EST, 4'd3);
        expectAt(LAT + PUR - 1, "purge_last_extractor", S_EXT, 4'd1);
        expectAll(LAT + PUR, "purge_done", 0, 0, 0, 2'd0, 4'b0000);
        tick(26);

        $display("[TB] smoke returns during purge");
        applyStimulus(0, 0, 0, 1, 0);
        expectAt(LAT, "re_alarma_estado", S_EST, 4'd1);
        tick(10);
        applyStimulus(0, 0, 0, 0, 0);
        expectAt(LAT, "re_purge_estado", S_EST, 4'd3);
        tick(10);
        applyStimulus(0, 0, 0, 1, 0);
        expectAt(LAT - 1, "re_pre_estado", S_EST, 4'd3);
        expectAt(LAT, "re_back_estado", S_EST, 4'd1);
        expectAt(LAT, "re_back_bocina", S_BOC, 4'd1);
        expectAt(LAT, "re_back_extractor", S_EXT, 4'd1);
        tick(10);
        applyStimulus(0, 0, 0, 0, 0);
        expectAt(LAT + PUR - 1, "re_last_estado", S_EST, 4'd3);
        expectAll(LAT + PUR, "re_done", 0, 0, 0, 2'd0, 4'b0000);
        tick(25);

        $display("[TB] overload latch");
        applyStimulus(0, 0, 1, 0, 0);
        expectAt(LAT - 1, "sobre_pre_int", S_INT, 4'd0);
        expectAll(LAT, "sobre_set", 0, 0, 1, 2'd0, 4'b0000);
        tick(10);
        applyStimulus(0, 0, 0, 0, 0);
        expectAll(10, "sobre_sticky", 0, 0, 1, 2'd0, 4'b0000);
        tick(10);
        applyStimulus(0, 0, 1, 0, 0);
        tick(10);
        applyStimulus(0, 0, 1, 0, 1);
        expectAt(LAT + 1, "ack_blocked_int", S_INT, 4'd1);
        expectAt(LAT + 1, "ack_blocked_estado", S_EST, 4'd0);
        tick(6);
        applyStimulus(0, 0, 0, 0, 0);
        tick(8);
        applyStimulus(0, 0, 0, 0, 1);
        expectAt(LAT - 1, "clr_pre_int", S_INT, 4'd1);
        expectAt(LAT, "clr_int", S_INT, 4'd0);
        tick(6);
        applyStimulus(0, 0, 0, 0, 0);
        tick(8);

        $display("[TB] reset during purge");
        applyStimulus(0, 0, 1, 1, 0);
        expectAt(LAT, "r6_alarma_estado", S_EST, 4'd1);
        expectAt(LAT, "r6_int", S_INT, 4'd1);
        tick(8);
        applyStimulus(0, 0, 0, 1, 0);
        tick(2);
        applyStimulus(0, 0, 0, 0, 0);
        tick(10);
        expectAt(0, "r6_in_purge", S_EST, 4'd3);
        expectAt(0, "r6_int_held", S_INT, 4'd1);
        rst_n = 1'b0;
        tick(1);
        expectAll(0, "r6_reset", 0, 0, 0, 2'd0, 4'b0000);
        rst_n = 1'b1;
        expectAll(5, "r6_after", 0, 0, 0, 2'd0, 4'b0000);
        tick(8);

        foreach (sb[i]) begin
            miscompares++;
            $display("[TB] FAIL %s: never checked, due cycle %0d", sb[i].tag, sb[i].due);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
